// File: rtl/counter_reg_pkg.sv
// Shared encodings for the counter register bank.
package counter_reg_pkg;

  // Overflow policy selected by the SAT_MODE parameter.
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Per-channel operation, already resolved for priority by the top level.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_WRITE,
    OP_CLR,
    OP_INC,
    OP_DEC
  } op_e;

endpackage

// File: rtl/counter_reg_cell.sv
// One counter channel: value register plus sticky overflow flag.
module counter_reg_cell
  import counter_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      SAT_MODE  = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  op_e              op,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] AllOnes  = '1;
  localparam logic [WIDTH-1:0] AllZeros = '0;
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);
  localparam bit               Saturate = (SAT_MODE == MODE_SAT);

  logic [WIDTH-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;

  // Next-state: apply the decoded op; boundary crossings set the sticky flag.
  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    unique case (op)
      OP_WRITE: begin
        value_d = datain;
        ovf_d   = 1'b0;
      end
      OP_CLR: begin
        value_d = AllZeros;
        ovf_d   = 1'b0;
      end
      OP_INC: begin
        if (value_q == AllOnes) begin
          ovf_d   = 1'b1;
          value_d = Saturate ? AllOnes : AllZeros;
        end else begin
          value_d = value_q + One;
        end
      end
      OP_DEC: begin
        if (value_q == AllZeros) begin
          ovf_d   = 1'b1;
          value_d = Saturate ? AllZeros : AllOnes;
        end else begin
          value_d = value_q - One;
        end
      end
      default: begin
        value_d = value_q;
        ovf_d   = ovf_q;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= RESET_VAL;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value = value_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/counter_reg_bank.sv
// Bank of independent counter registers with shared load bus and muxed read.
module counter_reg_bank
  import counter_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      CHANNELS  = 4,
  parameter int unsigned      SAT_MODE  = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      write_en,
  input  logic [SEL_W-1:0]          sel,
  input  logic [WIDTH-1:0]          datain,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic [WIDTH-1:0]          dataout,
  output logic [CHANNELS*WIDTH-1:0] data_all,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       ovf
);

  logic [WIDTH-1:0] value [CHANNELS];
  op_e              ch_op [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Out-of-range sel never matches any channel, so such writes fall through.
    logic wr_hit;
    assign wr_hit = write_en && (sel == SEL_W'(i));

    // Priority decode: write, clear, inc+dec cancel, inc, dec, hold.
    always_comb begin
      ch_op[i] = OP_HOLD;
      if (wr_hit) begin
        ch_op[i] = OP_WRITE;
      end else if (clr[i]) begin
        ch_op[i] = OP_CLR;
      end else if (inc[i] && dec[i]) begin
        ch_op[i] = OP_HOLD;
      end else if (inc[i]) begin
        ch_op[i] = OP_INC;
      end else if (dec[i]) begin
        ch_op[i] = OP_DEC;
      end
    end

    counter_reg_cell #(
      .WIDTH    (WIDTH),
      .SAT_MODE (SAT_MODE),
      .RESET_VAL(RESET_VAL)
    ) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .op     (ch_op[i]),
      .datain (datain),
      .value  (value[i]),
      .ovf    (ovf[i])
    );

    assign data_all[i*WIDTH +: WIDTH] = value[i];
    assign zero[i]                    = (value[i] == '0);
  end

  // Read mux; an out-of-range rd_sel reads as zero.
  always_comb begin
    dataout = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        dataout = value[i];
      end
    end
  end

endmodule

// File: tb/tb_counter_reg_bank.sv
// Scoreboard bench: three bank configurations share one stimulus stream.
module tb_counter_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        write_en;
  logic [1:0]  sel, rd_sel;
  logic [15:0] datain;
  logic [3:0]  clr, inc, dec;

  logic [63:0] all_a, all_b;
  logic [47:0] all_c;
  logic [15:0] dout_a, dout_b, dout_c;
  logic [3:0]  zero_a, zero_b, ovf_a, ovf_b;
  logic [2:0]  zero_c, ovf_c;

  // a: wrap, 4 ch, reset 0.  b: saturate, 4 ch, reset 0.  c: wrap, 3 ch, reset 0x0100.
  counter_reg_bank #(.WIDTH(16), .CHANNELS(4), .SAT_MODE(0), .RESET_VAL(16'h0000)) dut_a (
    .clk(clk), .reset_n(reset_n), .write_en(write_en), .sel(sel), .datain(datain),
    .clr(clr), .inc(inc), .dec(dec), .rd_sel(rd_sel), .dataout(dout_a),
    .data_all(all_a), .zero(zero_a), .ovf(ovf_a)
  );
  counter_reg_bank #(.WIDTH(16), .CHANNELS(4), .SAT_MODE(1), .RESET_VAL(16'h0000)) dut_b (
    .clk(clk), .reset_n(reset_n), .write_en(write_en), .sel(sel), .datain(datain),
    .clr(clr), .inc(inc), .dec(dec), .rd_sel(rd_sel), .dataout(dout_b),
    .data_all(all_b), .zero(zero_b), .ovf(ovf_b)
  );
  counter_reg_bank #(.WIDTH(16), .CHANNELS(3), .SAT_MODE(0), .RESET_VAL(16'h0100)) dut_c (
    .clk(clk), .reset_n(reset_n), .write_en(write_en), .sel(sel), .datain(datain),
    .clr(clr[2:0]), .inc(inc[2:0]), .dec(dec[2:0]), .rd_sel(rd_sel), .dataout(dout_c),
    .data_all(all_c), .zero(zero_c), .ovf(ovf_c)
  );

  typedef struct {
    logic [63:0] all  [3];
    logic [3:0]  zero [3];
    logic [3:0]  ovf  [3];
    logic [15:0] dout [3];
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  event async_chk;

  // Reference model: plain integer counters per configuration.
  int unsigned n_ch [3] = '{4, 4, 3};
  bit          sat  [3] = '{1'b0, 1'b1, 1'b0};
  int unsigned rv   [3] = '{0, 0, 256};
  int unsigned mv   [3][4];
  bit          mo   [3][4];

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) begin
        mv[d][i] = rv[d];
        mo[d][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < int'(n_ch[d]); i++) begin
        if (write_en && int'(sel) == i) begin
          mv[d][i] = datain;
          mo[d][i] = 1'b0;
        end else if (clr[i]) begin
          mv[d][i] = 0;
          mo[d][i] = 1'b0;
        end else if (inc[i] && dec[i]) begin
          // cancel out
        end else if (inc[i]) begin
          if (mv[d][i] + 1 > 65535) begin
            mo[d][i] = 1'b1;
            mv[d][i] = sat[d] ? 65535 : 0;
          end else mv[d][i] = mv[d][i] + 1;
        end else if (dec[i]) begin
          if (mv[d][i] == 0) begin
            mo[d][i] = 1'b1;
            mv[d][i] = sat[d] ? 0 : 65535;
          end else mv[d][i] = mv[d][i] - 1;
        end
      end
  endtask

  function automatic exp_t expected();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      e.all[d]  = '0;
      e.zero[d] = '0;
      e.ovf[d]  = '0;
      for (int i = 0; i < int'(n_ch[d]); i++) begin
        e.all[d][i*16 +: 16] = mv[d][i][15:0];
        e.zero[d][i]         = (mv[d][i] == 0);
        e.ovf[d][i]          = mo[d][i];
      end
      e.dout[d] = (int'(rd_sel) < int'(n_ch[d])) ? mv[d][rd_sel][15:0] : 16'h0;
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Pop one expected entry and compare every DUT output against it.
  task automatic check_top(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: actual empty scoreboard required an expected entry", tag);
      return;
    end
    e = sb_q.pop_front();
    cmp({tag, " a.data_all"}, all_a, e.all[0]);
    cmp({tag, " b.data_all"}, all_b, e.all[1]);
    cmp({tag, " c.data_all"}, {16'h0, all_c}, e.all[2]);
    cmp({tag, " a.zero"}, {60'h0, zero_a}, {60'h0, e.zero[0]});
    cmp({tag, " b.zero"}, {60'h0, zero_b}, {60'h0, e.zero[1]});
    cmp({tag, " c.zero"}, {61'h0, zero_c}, {60'h0, e.zero[2]});
    cmp({tag, " a.ovf"}, {60'h0, ovf_a}, {60'h0, e.ovf[0]});
    cmp({tag, " b.ovf"}, {60'h0, ovf_b}, {60'h0, e.ovf[1]});
    cmp({tag, " c.ovf"}, {61'h0, ovf_c}, {60'h0, e.ovf[2]});
    cmp({tag, " a.dataout"}, {48'h0, dout_a}, {48'h0, e.dout[0]});
    cmp({tag, " b.dataout"}, {48'h0, dout_b}, {48'h0, e.dout[1]});
    cmp({tag, " c.dataout"}, {48'h0, dout_c}, {48'h0, e.dout[2]});
  endtask

  // Monitors: after each edge, and shortly after an asynchronous reset assertion.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) check_top("edge");
  end

  always @(async_chk) begin
    #1;
    check_top("async");
  end

  task automatic drive(input logic we, input logic [1:0] s, input logic [15:0] d,
                       input logic [3:0] c, input logic [3:0] i, input logic [3:0] de,
                       input logic [1:0] rs);
    write_en = we;
    sel      = s;
    datain   = d;
    clr      = c;
    inc      = i;
    dec      = de;
    rd_sel   = rs;
  endtask

  // Called at a negedge with inputs driven; returns at the following negedge.
  task automatic step();
    if (reset_n) model_edge();
    else model_reset();
    sb_q.push_back(expected());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    model_reset();
    sb_q.push_back(expected());
    ->async_chk;
  endtask

  function automatic logic [15:0] pick_data();
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'hFFFE;
      2: return 16'h0000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_drive();
    drive(($urandom_range(0, 3) == 0), 2'($urandom), pick_data(),
          ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
          4'($urandom), 4'($urandom), 2'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    model_reset();
    @(negedge clk);
    async_reset();
    step();
    reset_n = 1'b1;

    // Load and count up on channel 2.
    drive(1'b1, 2'd2, 16'h1234, 4'h0, 4'h0, 4'h0, 2'd2);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'd0, 16'h0, 4'h0, 4'b0100, 4'h0, 2'd2);
      step();
    end
    cmp("t1 a.dataout", {48'h0, dout_a}, {48'h0, 16'h1237});
    cmp("t1 a.zero", {60'h0, zero_a}, {60'h0, 4'b1011});

    // Wrap past all-ones on channel 1, back down, then clear.
    drive(1'b1, 2'd1, 16'hFFFF, 4'h0, 4'h0, 4'h0, 2'd1);
    step();
    drive(1'b0, 2'd0, 16'h0, 4'h0, 4'b0010, 4'h0, 2'd1);
    step();
    cmp("t2 a.ch1", {48'h0, all_a[31:16]}, 64'h0);
    cmp("t2 a.ovf1", {63'h0, ovf_a[1]}, 64'h1);
    drive(1'b0, 2'd0, 16'h0, 4'h0, 4'h0, 4'b0010, 2'd1);
    step();
    drive(1'b0, 2'd0, 16'h0, 4'b0010, 4'h0, 4'h0, 2'd1);
    step();

    // Underflow and overflow on channel 0 (saturation seen on bank b).
    drive(1'b0, 2'd0, 16'h0, 4'b0001, 4'h0, 4'h0, 2'd0);
    step();
    drive(1'b0, 2'd0, 16'h0, 4'h0, 4'h0, 4'b0001, 2'd0);
    step();
    cmp("t3 b.ch0", {48'h0, all_b[15:0]}, 64'h0);
    cmp("t3 b.ovf0", {63'h0, ovf_b[0]}, 64'h1);
    drive(1'b1, 2'd0, 16'hFFFF, 4'h0, 4'h0, 4'h0, 2'd0);
    step();
    drive(1'b0, 2'd0, 16'h0, 4'h0, 4'b0001, 4'h0, 2'd0);
    step();
    cmp("t3 b.dataout", {48'h0, dout_b}, {48'h0, 16'hFFFF});

    // Same-cycle priority on channel 3; out-of-range for bank c.
    drive(1'b1, 2'd3, 16'h00AA, 4'b1000, 4'b1000, 4'h0, 2'd3);
    step();
    drive(1'b0, 2'd0, 16'h0, 4'h0, 4'b1000, 4'b1000, 2'd3);
    step();
    cmp("t4 a.dataout", {48'h0, dout_a}, {48'h0, 16'h00AA});
    cmp("t5 c.dataout", {48'h0, dout_c}, 64'h0);

    // Randomised traffic with occasional mid-stream asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      rand_drive();
      if (n % 100 == 50) begin
        #1;
        async_reset();
        #3;
        cmp("t6 c.data_all", {16'h0, all_c}, {16'h0, {3{16'h0100}}});
        step();
        rand_drive();
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end

    @(posedge clk);
    #3;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: actual %0d pending required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
